dcache_write_buffer: RTL and testbench

- Posted-write FIFO between the dcache write path and the main-memory write port owned by the cache arbiter.
- Absorbs dcache write-through stores: the CPU pipeline continues while stores drain to main memory in cycles when no cache fill owns the memory port.
- Provides read-after-write forwarding, so a dcache miss fill never returns data older than a buffered store.

---
 rtl/dcache_write_buffer.sv | 95 +++++++++
 tb/tb_dcache_write_buffer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dcache_write_buffer.sv
// Posted-write FIFO between the dcache write-through path and the main-memory write port.
// Coalesces repeated stores to the newest address and forwards buffered data to fills.
module dcache_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid,
  input  logic [AW-1:0]            enq_addr,
  input  logic [DW-1:0]            enq_data,
  output logic                     enq_ready,
  input  logic                     drain_en,
  input  logic                     mem_busy,
  output logic                     mem_wr_en,
  output logic [AW-1:0]            mem_wr_addr,
  output logic [DW-1:0]            mem_wr_data,
  input  logic [AW-1:0]            lookup_addr,
  output logic                     lookup_hit,
  output logic [DW-1:0]            lookup_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, newest;
  logic [CW-1:0] count_q, count_d;
  logic          enq_fire, deq_fire, coalesce, push;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign count       = count_q;
  assign enq_ready   = ~full;
  assign mem_wr_en   = ~empty & drain_en;
  assign mem_wr_addr = addr_q[head_q];
  assign mem_wr_data = data_q[head_q];

  assign enq_fire = enq_valid & enq_ready;
  assign deq_fire = mem_wr_en & ~mem_busy;
  assign newest   = tail_q - PW'(1);

  // A lone entry leaving this cycle must not absorb the store, or the new data would be lost.
  assign coalesce = enq_fire & ~empty & (addr_q[newest] == enq_addr)
                  & ~((count_q == CW'(1)) & deq_fire);
  assign push     = enq_fire & ~coalesce;

  always_comb begin
    head_d  = deq_fire ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(push) - CW'(deq_fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= enq_addr;
      data_q[tail_q] <= enq_data;
    end else if (coalesce) begin
      data_q[newest] <= enq_data;
    end
  end

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Scoreboard bench for dcache_write_buffer: a queue-based model predicts status, forwarding
// and the memory write stream; a monitor process pops and compares against the DUT.
module tb_dcache_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enq_valid = 1'b0;
  logic [AW-1:0] enq_addr = '0;
  logic [DW-1:0] enq_data = '0;
  logic          enq_ready;
  logic          drain_en = 1'b0;
  logic          mem_busy = 1'b0;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic [AW-1:0] lookup_addr = '0;
  logic          lookup_hit;
  logic [DW-1:0] lookup_data;
  logic [2:0]    count;
  logic          empty;
  logic          full;

  dcache_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_addr(enq_addr), .enq_data(enq_data), .enq_ready(enq_ready),
    .drain_en(drain_en), .mem_busy(mem_busy),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  typedef struct {
    int            cnt;
    bit            emp, ful, rdy, wen, hit;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hdata, ldata;
  } stat_t;

  ent_t  model[$];
  stat_t stat_q[$];
  ent_t  wr_q[$];
  bit    armed = 1'b0;
  int    nchk  = 0;
  int    npass = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One clock cycle: drive inputs, predict outputs from the model, then advance the model.
  task automatic cyc(input bit r, input bit ev, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                     input bit de, input bit mb, input logic [AW-1:0] la);
    stat_t s;
    int    n;
    bit    deq, fire, coal;
    @(negedge clk);
    rst = r; enq_valid = ev; enq_addr = ea; enq_data = ed;
    drain_en = de; mem_busy = mb; lookup_addr = la;
    n = model.size();
    s.cnt = n; s.emp = (n == 0); s.ful = (n == DEPTH); s.rdy = (n != DEPTH);
    s.wen = (n != 0) && de;
    s.haddr = (n != 0) ? model[0].a : '0;
    s.hdata = (n != 0) ? model[0].d : '0;
    s.hit = 1'b0; s.ldata = '0;
    for (int i = 0; i < n; i++)
      if (model[i].a == la) begin s.hit = 1'b1; s.ldata = model[i].d; end
    deq  = s.wen && !mb;
    fire = ev && s.rdy;
    coal = fire && (n > 0) && (model[n-1].a == ea) && !(n == 1 && deq);
    if (armed) begin
      stat_q.push_back(s);
      if (deq) wr_q.push_back(model[0]);
    end
    if (r) model.delete();
    else begin
      if (coal) model[n-1].d = ed;
      if (deq) void'(model.pop_front());
      if (fire && !coal) model.push_back('{a: ea, d: ed});
    end
    @(posedge clk);
    if (r) armed = 1'b1;
  endtask

  initial begin : monitor
    stat_t s;
    ent_t  w;
    forever begin
      @(negedge clk);
      #3;
      if (stat_q.size() > 0) begin
        s = stat_q.pop_front();
        chk("count", int'(count), s.cnt);
        chk("empty", int'(empty), int'(s.emp));
        chk("full", int'(full), int'(s.ful));
        chk("enq_ready", int'(enq_ready), int'(s.rdy));
        chk("mem_wr_en", int'(mem_wr_en), int'(s.wen));
        if (s.wen) begin
          chk("head_addr", int'(mem_wr_addr), int'(s.haddr));
          chk("head_data", int'(mem_wr_data), int'(s.hdata));
        end
        chk("lookup_hit", int'(lookup_hit), int'(s.hit));
        chk("lookup_data", int'(lookup_data), int'(s.ldata));
      end
      if (armed && mem_wr_en && !mem_busy) begin
        if (wr_q.size() == 0) begin
          chk("write_expected", 0, 1);
        end else begin
          w = wr_q.pop_front();
          chk("wr_addr", int'(mem_wr_addr), int'(w.a));
          chk("wr_data", int'(mem_wr_data), int'(w.d));
        end
      end
    end
  end

  initial begin : stimulus
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Single store held with drain off, then looked up.
    cyc(0, 1, 16'h0010, 16'hAAAA, 0, 0, 16'h0010);
    cyc(0, 0, 0, 0, 0, 0, 16'h0010);
    // Fill to four, fifth store ignored, then drain in order.
    cyc(0, 1, 16'h0011, 16'hB001, 0, 0, 16'h0011);
    cyc(0, 1, 16'h0012, 16'hB002, 0, 0, 16'h0010);
    cyc(0, 1, 16'h0013, 16'hB003, 0, 0, 16'h0012);
    cyc(0, 1, 16'h0014, 16'hB004, 0, 0, 16'h0014);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 0, 16'h0013);
    // Coalescing into the newest entry; youngest match forwards.
    cyc(0, 1, 16'h0020, 16'h1111, 0, 0, 16'h0020);
    cyc(0, 1, 16'h0020, 16'h2222, 0, 0, 16'h0020);
    cyc(0, 1, 16'h0030, 16'h3333, 0, 0, 16'h0020);
    cyc(0, 1, 16'h0020, 16'h4444, 0, 0, 16'h0020);
    cyc(0, 0, 0, 0, 0, 0, 16'h0020);
    cyc(1, 0, 0, 0, 0, 0, 16'h0020);
    // Busy memory holds the head write stable.
    cyc(0, 1, 16'h0040, 16'hBEEF, 0, 0, 16'h0040);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 1, 16'h0040);
    cyc(0, 0, 0, 0, 1, 0, 16'h0040);
    cyc(0, 0, 0, 0, 1, 0, 16'h0040);
    // Full with simultaneous enqueue and dequeue, then steady-state wrap at count 2.
    for (int i = 0; i < 4; i++) cyc(0, 1, 16'h0050 + 16'(i), 16'hC000 + 16'(i), 0, 0, 0);
    cyc(0, 1, 16'h005F, 16'hCFFF, 1, 0, 16'h005F);
    cyc(0, 0, 0, 0, 1, 0, 16'h0053);
    for (int i = 0; i < 10; i++)
      cyc(0, 1, 16'h0060 + 16'(i), 16'hD000 + 16'(i), 1, 0, 16'h0060 + 16'(i));
    // Reset mid-drain discards everything.
    cyc(0, 1, 16'h0070, 16'hE000, 1, 1, 0);
    cyc(0, 1, 16'h0071, 16'hE001, 1, 1, 0);
    cyc(1, 0, 0, 0, 1, 0, 16'h0070);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0, 16'h0068 + 16'(i));
    // Randomized traffic over a small address set to provoke coalescing and hits.
    for (int i = 0; i < 1500; i++)
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
          16'h0100 + 16'($urandom_range(0, 5)), 16'($urandom),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
          16'h0100 + 16'($urandom_range(0, 6)));
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1, 0, 16'h0100);
    @(negedge clk);
    #4;
    chk("writes_outstanding", wr_q.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
